eca_row_engine: RTL and testbench

Parametrised elementary-cellular-automaton row engine, the successor to the single 2:1 selector. Each cell's next state is an 8:1 selection from the 8-bit Wolfram rule, with the cell's 3-bit neighbourhood as the select. The block holds a WIDTH-cell row, steps it one generation per clock for a programmed number of generations, and offers selectable boundary handling. It sits between the seed/rule configuration logic and the display/capture logic.

---
 rtl/eca_row_engine.sv | 120 ++++++++++++
 tb/tb_eca_row_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/eca_row_engine.sv
// Elementary cellular automaton row engine: steps a WIDTH-cell row one
// generation per clock under an 8-bit Wolfram rule with selectable boundaries.

module eca_cell (
  input  logic [2:0] nbr_i,
  input  logic [7:0] rule_i,
  output logic       nxt_o
);
  assign nxt_o = rule_i[nbr_i];
endmodule

module eca_row_engine #(
  parameter int WIDTH = 16,
  parameter int GEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [7:0]       rule,
  input  logic [1:0]       bnd_mode,
  input  logic [GEN_W-1:0] num_gens,
  input  logic             start,
  input  logic             halt,
  output logic [WIDTH-1:0] row,
  output logic             row_valid,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic [7:0]       rule;
    logic [1:0]       mode;
    logic [GEN_W-1:0] rem;
  } cfg_t;

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [WIDTH-1:0] row_q, row_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             vld_q, vld_d;

  logic             bnd_val, wrap;
  logic [WIDTH+1:0] ext;
  logic [WIDTH-1:0] nxt_row;

  // Row padded with its left/right neighbours so every cell sees {L,C,R}
  // as a contiguous 3-bit slice.
  assign bnd_val = (cfg_q.mode == 2'd1);
  assign wrap    = (cfg_q.mode == 2'd2);
  assign ext     = {wrap ? row_q[0] : bnd_val, row_q, wrap ? row_q[WIDTH-1] : bnd_val};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    eca_cell u_cell (
      .nbr_i  (ext[i+2:i]),
      .rule_i (cfg_q.rule),
      .nxt_o  (nxt_row[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    row_d   = row_q;
    gen_d   = gen_q;
    vld_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          row_d = seed;
          gen_d = '0;
        end else if (start) begin
          cfg_d.rule = rule;
          cfg_d.mode = bnd_mode;
          cfg_d.rem  = num_gens;
          state_d    = (num_gens == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_DONE;
        end else begin
          row_d     = nxt_row;
          gen_d     = (&gen_q) ? gen_q : gen_q + 1'b1;
          cfg_d.rem = cfg_q.rem - 1'b1;
          vld_d     = 1'b1;
          if (cfg_q.rem == GEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      row_q   <= '0;
      gen_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      row_q   <= row_d;
      gen_q   <= gen_d;
      vld_q   <= vld_d;
    end
  end

  assign row       = row_q;
  assign row_valid = vld_q;
  assign gen_count = gen_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_eca_row_engine.sv
// Randomized + directed bench for eca_row_engine against a per-run behavioural
// model that predicts every cycle's outputs.

module tb_eca_row_engine;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load, start, halt;
  logic [W-1:0]  seed;
  logic [7:0]    rule;
  logic [1:0]    bnd_mode;
  logic [7:0]    num_gens;
  logic [W-1:0]  row;
  logic          row_valid, busy, done;
  logic [7:0]    gen_count;

  eca_row_engine #(.WIDTH(W), .GEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .seed(seed), .rule(rule),
    .bnd_mode(bnd_mode), .num_gens(num_gens), .start(start), .halt(halt),
    .row(row), .row_valid(row_valid), .gen_count(gen_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_vld, n_done, n_busy;
  bit chk_en = 1'b0;
  logic [W-1:0] m_row, e_row;
  logic [7:0]   m_gen, e_gen;
  logic         e_vld, e_busy, e_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Next generation from the rule definition: bit idx of the rule number.
  function automatic logic [W-1:0] eca_next(input logic [W-1:0] r, input logic [7:0] ru,
                                             input logic [1:0] md);
    logic [W-1:0] o;
    int l, c, rr, b;
    b = (md == 2'd1) ? 1 : 0;
    for (int i = 0; i < W; i++) begin
      c  = int'(r[i]);
      l  = (i == W-1 && md != 2'd2) ? b : int'(r[(i+1) % W]);
      rr = (i == 0   && md != 2'd2) ? b : int'(r[(i+W-1) % W]);
      o[i] = ((int'(ru) >> (l*4 + c*2 + rr)) & 1) != 0;
    end
    return o;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("row", row, e_row);
      chk("row_valid", row_valid, e_vld);
      chk("gen_count", gen_count, e_gen);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
    end
    if (row_valid) n_vld++;
    if (done) n_done++;
    if (busy) n_busy++;
  end

  task automatic step_exp(input logic [W-1:0] r, input logic v, input logic b, input logic d);
    @(posedge clk); #1;
    e_row = r; e_vld = v; e_busy = b; e_done = d; e_gen = m_gen;
  endtask

  task automatic do_load(input logic [W-1:0] s);
    load = 1'b1; seed = s;
    m_row = s; m_gen = 8'd0;
    step_exp(m_row, 0, 0, 0);
    load = 1'b0;
  endtask

  // halt_at = number of updates completed before halt is raised (-1: never).
  task automatic do_run(input logic [7:0] ru, input logic [1:0] md, input int n,
                        input int halt_at, input bit junk);
    rule = ru; bnd_mode = md; num_gens = n[7:0]; start = 1'b1;
    n_vld = 0; n_done = 0; n_busy = 0;
    step_exp(m_row, 0, n != 0, n == 0);
    start = 1'b0;
    rule = 8'($urandom); bnd_mode = 2'($urandom); num_gens = 8'($urandom);
    if (junk) begin load = 1'b1; seed = 16'hFFFF; start = 1'b1; rule = 8'd0; end
    for (int k = 1; k <= n; k++) begin
      if (halt_at == k-1) begin
        halt = 1'b1;
        step_exp(m_row, 0, 0, 1);
        halt = 1'b0;
        break;
      end
      m_row = eca_next(m_row, ru, md);
      if (m_gen != 8'hFF) m_gen++;
      step_exp(m_row, 1, k < n, k == n);
    end
    step_exp(m_row, 0, 0, 0);
    load = 1'b0; start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 0; start = 0; halt = 0; seed = '0; rule = '0;
    bnd_mode = '0; num_gens = '0;
    m_row = '0; m_gen = '0;
    e_row = '0; e_gen = '0; e_vld = 0; e_busy = 0; e_done = 0;
    n_vld = 0; n_done = 0; n_busy = 0;
    chk_en = 1'b1;
    #12 rst_n = 1'b1;
    step_exp('0, 0, 0, 0);

    chk("pin_model_r90", eca_next(16'h0080, 8'd90, 2'd0), 32'h0140);
    chk("pin_model_wrap", eca_next(16'h0001, 8'd90, 2'd2), 32'h8002);

    // basic rule 90 run
    do_load(16'h0080);
    do_run(8'd90, 2'd0, 2, -1, 0);
    chk("t1_row", row, 32'h0220); chk("t1_gen", gen_count, 2);
    chk("t1_vld", n_vld, 2); chk("t1_done", n_done, 1); chk("t1_busy", n_busy, 2);

    // boundary modes
    do_load(16'h0001); do_run(8'd90, 2'd2, 1, -1, 0); chk("t2_wrap", row, 32'h8002);
    do_load(16'h0001); do_run(8'd90, 2'd0, 1, -1, 0); chk("t2_zero", row, 32'h0002);
    do_load(16'h0000); do_run(8'd90, 2'd1, 1, -1, 0); chk("t2_ones", row, 32'h8001);
    do_load(16'h0000); do_run(8'd90, 2'd3, 1, -1, 0); chk("t2_rsvd", row, 32'h0000);

    // zero-generation run
    do_load(16'hA5A5); do_run(8'd90, 2'd0, 0, -1, 0);
    chk("t3_done", n_done, 1); chk("t3_busy", n_busy, 0); chk("t3_vld", n_vld, 0);
    chk("t3_row", row, 32'hA5A5); chk("t3_gen", gen_count, 0);

    // identity rule, cumulative gen_count
    do_load(16'h1234); do_run(8'd204, 2'd0, 5, -1, 0);
    chk("t4_row", row, 32'h1234); chk("t4_gen", gen_count, 5); chk("t4_vld", n_vld, 5);
    do_run(8'd204, 2'd0, 5, -1, 0); chk("t4_gen2", gen_count, 10);

    // halt after 2 updates
    do_load(16'h0080); do_run(8'd90, 2'd0, 10, 2, 0);
    chk("t5_row", row, 32'h0220); chk("t5_gen", gen_count, 2); chk("t5_done", n_done, 1);

    // reset mid-run
    do_load(16'h0080);
    rule = 8'd90; bnd_mode = 2'd0; num_gens = 8'd10; start = 1'b1;
    n_done = 0;
    step_exp(m_row, 0, 1, 0);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_row = eca_next(m_row, 8'd90, 2'd0); m_gen++;
      step_exp(m_row, 1, 1, 0);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("t5r_row", row, 0); chk("t5r_busy", busy, 0); chk("t5r_gen", gen_count, 0);
    chk("t5r_vld", row_valid, 0); chk("t5r_done", done, 0);
    m_row = '0; m_gen = '0;
    e_row = '0; e_gen = '0; e_vld = 0; e_busy = 0; e_done = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    step_exp('0, 0, 0, 0);
    step_exp('0, 0, 0, 0);
    chk("t5r_nodone", n_done, 0);

    // inputs ignored mid-run, then load+start together
    do_load(16'h0080); do_run(8'd90, 2'd0, 2, -1, 1);
    chk("t6_row", row, 32'h0220); chk("t6_gen", gen_count, 2);
    n_busy = 0;
    load = 1'b1; start = 1'b1; seed = 16'h5A5A; num_gens = 8'd3; rule = 8'd90;
    m_row = 16'h5A5A; m_gen = 8'd0;
    step_exp(m_row, 0, 0, 0);
    load = 1'b0; start = 1'b0;
    step_exp(m_row, 0, 0, 0);
    chk("t6_ls_row", row, 32'h5A5A); chk("t6_ls_busy", n_busy, 0);

    // gen_count saturation
    do_load(16'h0001);
    do_run(8'd204, 2'd0, 200, -1, 0);
    do_run(8'd204, 2'd0, 100, -1, 0);
    chk("sat_gen", gen_count, 32'hFF);

    // random runs
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) do_load(16'($urandom));
      do_run(8'($urandom), 2'($urandom), int'($urandom_range(0, 8)),
             ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 9)),
             bit'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
